uv_alu_pipe: RTL

Pipelined, parametrised ALU for the integer execute stage, replacing the single-cycle one-hot-controlled ALU.
- Takes an encoded opcode with valid/ready handshakes on both sides and carries a tag for the issue logic.
- Fixed 2-stage latency, throughput of one op per cycle, full backpressure support, synchronous flush.
- Adds 64-bit datapath support, RV64 word (W) ops and optional min/max.

---
 rtl/uv_alu_pkg.sv | 35 +++
 rtl/uv_alu_dp.sv | 73 +++++++
 rtl/uv_alu_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uv_alu_pkg.sv
// uv_alu_pkg: opcode encoding and legality decode shared by decode and execute.
// Define UV_ALU_MINMAX_EN to make the MIN/MAX opcodes legal.
package uv_alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t UV_ALU_OP_ADD = 4'd0;
   localparam alu_op_t UV_ALU_OP_SUB = 4'd1;
   localparam alu_op_t UV_ALU_OP_SLL = 4'd2;
   localparam alu_op_t UV_ALU_OP_SR  = 4'd3;
   localparam alu_op_t UV_ALU_OP_XOR = 4'd4;
   localparam alu_op_t UV_ALU_OP_OR  = 4'd5;
   localparam alu_op_t UV_ALU_OP_AND = 4'd6;
   localparam alu_op_t UV_ALU_OP_SLT = 4'd7;
   localparam alu_op_t UV_ALU_OP_LUI = 4'd8;
   localparam alu_op_t UV_ALU_OP_MIN = 4'd9;
   localparam alu_op_t UV_ALU_OP_MAX = 4'd10;

   function automatic logic uv_alu_legal(input alu_op_t op, input logic word);
      logic ok;
      if (word) begin
         ok = (op == UV_ALU_OP_ADD) | (op == UV_ALU_OP_SUB) |
              (op == UV_ALU_OP_SLL) | (op == UV_ALU_OP_SR);
      end else begin
         ok = (op <= UV_ALU_OP_LUI);
`ifdef UV_ALU_MINMAX_EN
         ok = ok | (op == UV_ALU_OP_MIN) | (op == UV_ALU_OP_MAX);
`endif
      end
      return ok;
   endfunction

endpackage

// File: rtl/uv_alu_dp.sv
// uv_alu_dp: combinational ALU datapath (extended adder, reversed-left shifter,
// logic ops, equality). Word-mode operands are prepared here for the shifter.
module uv_alu_dp
   import uv_alu_pkg::*;
#(
   parameter int ALU_DW = 32,
   parameter int SFT_DW = 5
) (
   input  logic [ALU_OP_W-1:0] i_op,
   input  logic                i_sgn,
   input  logic                i_word,
   input  logic [ALU_DW-1:0]   i_opa,
   input  logic [ALU_DW-1:0]   i_opb,
   output logic [ALU_DW-1:0]   o_sum,
   output logic                o_lt,
   output logic                o_eq,
   output logic [ALU_DW-1:0]   o_sft,
   output logic [ALU_DW-1:0]   o_xor,
   output logic [ALU_DW-1:0]   o_or,
   output logic [ALU_DW-1:0]   o_and
);

   localparam logic [ALU_DW:0] ONE = 1;

   logic [ALU_DW:0]   w_xa;
   logic [ALU_DW:0]   w_xb;
   logic [ALU_DW:0]   w_dif;
   logic [ALU_DW-1:0] w_add;

   assign w_xa  = {i_sgn & i_opa[ALU_DW-1], i_opa};
   assign w_xb  = {i_sgn & i_opb[ALU_DW-1], i_opb};
   assign w_dif = w_xa + ~w_xb + ONE;
   assign w_add = i_opa + i_opb;

   assign o_sum = (i_op == UV_ALU_OP_ADD) ? w_add : w_dif[ALU_DW-1:0];
   assign o_lt  = w_dif[ALU_DW];
   assign o_eq  = (i_opa == i_opb);
   assign o_xor = i_opa ^ i_opb;
   assign o_or  = i_opa | i_opb;
   assign o_and = i_opa & i_opb;

   logic [SFT_DW-1:0] w_amt;
   logic [ALU_DW-1:0] w_src;
   logic [ALU_DW-1:0] w_in;
   logic [ALU_DW-1:0] w_shl;
   logic [ALU_DW-1:0] w_msk;
   logic [ALU_DW-1:0] w_l;
   logic              w_right;
   logic              w_fill;

   // Right shifts run through the left shifter on bit-reversed data; SRA fill
   // is OR-ed into the vacated low bits before reversing back.
   always_comb begin
      w_amt = i_opb[SFT_DW-1:0];
      w_src = i_opa;
      if (i_word) begin
         for (int k = 5; k < SFT_DW; k++) w_amt[k] = 1'b0;
         for (int k = 32; k < ALU_DW; k++) w_src[k] = i_sgn & i_opa[31];
      end
      w_right = (i_op == UV_ALU_OP_SR);
      w_fill  = w_right & i_sgn & w_src[ALU_DW-1];
      w_in    = w_src;
      if (w_right)
         for (int k = 0; k < ALU_DW; k++) w_in[k] = w_src[ALU_DW-1-k];
      w_shl = w_in << w_amt;
      w_msk = ~({ALU_DW{1'b1}} << w_amt);
      w_l   = w_shl | (w_fill ? w_msk : '0);
      o_sft = w_l;
      if (w_right)
         for (int k = 0; k < ALU_DW; k++) o_sft[k] = w_l[ALU_DW-1-k];
   end

endmodule

// File: rtl/uv_alu_pipe.sv
// uv_alu_pipe: 2-stage pipelined ALU with valid/ready on both sides and flush.
// Optional MIN/MAX result path is enabled by UV_ALU_MINMAX_EN.
module uv_alu_pipe
   import uv_alu_pkg::*;
#(
   parameter int ALU_DW = 32,
   parameter int SFT_DW = 5,
   parameter int TAG_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_vld,
   output logic                in_rdy,
   input  logic [ALU_OP_W-1:0] in_op,
   input  logic                in_sgn,
   input  logic                in_word,
   input  logic [TAG_W-1:0]    in_tag,
   input  logic [ALU_DW-1:0]   in_opa,
   input  logic [ALU_DW-1:0]   in_opb,
   output logic                out_vld,
   input  logic                out_rdy,
   output logic [ALU_DW-1:0]   out_res,
   output logic [TAG_W-1:0]    out_tag,
   output logic                out_eq,
   output logic                out_lt,
   output logic                out_ill
);

   localparam logic W_EN = (ALU_DW == 64);

   logic w_word;
   logic w_ill;
   logic w_s1_rdy;
   logic w_s2_rdy;
   logic w_acc;

   logic [ALU_DW-1:0] w_sum;
   logic [ALU_DW-1:0] w_sft;
   logic [ALU_DW-1:0] w_xor;
   logic [ALU_DW-1:0] w_or;
   logic [ALU_DW-1:0] w_and;
   logic              w_lt;
   logic              w_eq;
   logic [ALU_DW-1:0] w_res;

   logic                r1_vld;
   logic [ALU_OP_W-1:0] r1_op;
   logic                r1_word;
   logic                r1_ill;
   logic [TAG_W-1:0]    r1_tag;
   logic [ALU_DW-1:0]   r1_sum;
   logic [ALU_DW-1:0]   r1_sft;
   logic [ALU_DW-1:0]   r1_xor;
   logic [ALU_DW-1:0]   r1_or;
   logic [ALU_DW-1:0]   r1_and;
   logic [ALU_DW-1:0]   r1_opb;
   logic                r1_lt;
   logic                r1_eq;
`ifdef UV_ALU_MINMAX_EN
   logic [ALU_DW-1:0]   r1_opa;
`endif

   logic              r2_vld;
   logic [ALU_DW-1:0] r2_res;
   logic [TAG_W-1:0]  r2_tag;
   logic              r2_eq;
   logic              r2_lt;
   logic              r2_ill;

   assign w_word   = in_word & W_EN;
   assign w_ill    = ~uv_alu_legal(in_op, w_word);
   assign w_s2_rdy = ~r2_vld | out_rdy;
   assign w_s1_rdy = ~r1_vld | w_s2_rdy;
   assign in_rdy   = w_s1_rdy & ~flush;
   assign w_acc    = in_vld & in_rdy;

   uv_alu_dp #(
      .ALU_DW (ALU_DW),
      .SFT_DW (SFT_DW)
   ) u_dp (
      .i_op   (in_op),
      .i_sgn  (in_sgn),
      .i_word (w_word),
      .i_opa  (in_opa),
      .i_opb  (in_opb),
      .o_sum  (w_sum),
      .o_lt   (w_lt),
      .o_eq   (w_eq),
      .o_sft  (w_sft),
      .o_xor  (w_xor),
      .o_or   (w_or),
      .o_and  (w_and)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         r1_vld <= 1'b0;
      else if (flush)
         r1_vld <= 1'b0;
      else if (w_s1_rdy)
         r1_vld <= w_acc;
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r1_op   <= in_op;
         r1_word <= w_word;
         r1_ill  <= w_ill;
         r1_tag  <= in_tag;
         r1_sum  <= w_sum;
         r1_sft  <= w_sft;
         r1_xor  <= w_xor;
         r1_or   <= w_or;
         r1_and  <= w_and;
         r1_opb  <= in_opb;
         r1_lt   <= w_lt;
         r1_eq   <= w_eq;
`ifdef UV_ALU_MINMAX_EN
         r1_opa  <= in_opa;
`endif
      end
   end

   always_comb begin
      w_res = '0;
      case (r1_op)
         UV_ALU_OP_ADD,
         UV_ALU_OP_SUB: w_res = r1_sum;
         UV_ALU_OP_SLL,
         UV_ALU_OP_SR:  w_res = r1_sft;
         UV_ALU_OP_XOR: w_res = r1_xor;
         UV_ALU_OP_OR:  w_res = r1_or;
         UV_ALU_OP_AND: w_res = r1_and;
         UV_ALU_OP_SLT: w_res[0] = r1_lt;
         UV_ALU_OP_LUI: w_res = r1_opb;
`ifdef UV_ALU_MINMAX_EN
         UV_ALU_OP_MIN: w_res = r1_lt ? r1_opa : r1_opb;
         UV_ALU_OP_MAX: w_res = r1_lt ? r1_opb : r1_opa;
`endif
         default:       w_res = '0;
      endcase
      if (r1_word)
         for (int k = 32; k < ALU_DW; k++) w_res[k] = w_res[31];
      if (r1_ill)
         w_res = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r2_vld <= 1'b0;
      else if (flush)
         r2_vld <= 1'b0;
      else if (w_s2_rdy)
         r2_vld <= r1_vld;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r2_res <= '0;
         r2_tag <= '0;
         r2_eq  <= 1'b0;
         r2_lt  <= 1'b0;
         r2_ill <= 1'b0;
      end else if (!flush && w_s2_rdy && r1_vld) begin
         r2_res <= w_res;
         r2_tag <= r1_tag;
         r2_eq  <= r1_eq & ~r1_ill;
         r2_lt  <= r1_lt & ~r1_ill;
         r2_ill <= r1_ill;
      end
   end

   assign out_vld = r2_vld;
   assign out_res = r2_res;
   assign out_tag = r2_tag;
   assign out_eq  = r2_eq;
   assign out_lt  = r2_lt;
   assign out_ill = r2_ill;

endmodule
